wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage plus architectural register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs and selects the destination register and write-back data.
- Writes the 32x32 register file and serves the two ID-stage read ports.
- Exports the resolved write-back bus (address/data/enable) to the forwarding unit.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- RA_IDX, 31, link register index used for jal/jalr
- XP_IDX, 26, exception PC register index ($k0) used on interrupt/exception entry

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous active-low reset
- RegDst_in  in  2  destination select from MEM/WB
- RegWr_in  in  1  register write enable from MEM/WB
- MemToReg_in  in  2  write-data select from MEM/WB
- PC_plus_4_in  in  DATA_W  PC+4 of retiring instruction
- ALU_in  in  DATA_W  ALU result
- mem_data_in  in  DATA_W  load data
- Rt_in  in  ADDR_W  rt field
- Rd_in  in  ADDR_W  rd field
- rs_addr  in  ADDR_W  ID read port 1 address
- rt_addr  in  ADDR_W  ID read port 2 address
- rs_data  out  DATA_W  ID read port 1 data
- rt_data  out  DATA_W  ID read port 2 data
- wb_en  out  1  effective write enable (to forwarding unit)
- wb_addr  out  ADDR_W  resolved destination index
- wb_data  out  DATA_W  resolved write data

Behaviour:
- One clock (clk). Reset is synchronous and active-low (reset), sampled on the rising edge of clk.
- RegDst decode:
  - 00 -> Rt_in
  - 01 -> Rd_in
  - 10 -> RA_IDX
  - 11 -> XP_IDX
- MemToReg decode:
  - 00 -> ALU_in
  - 01 -> mem_data_in
  - 10 -> PC_plus_4_in
  - 11 -> PC_plus_4_in (exception entry saves the return address)
- wb_addr and wb_data are combinational from the current inputs.
- wb_en = RegWr_in AND (wb_addr != 0) AND reset. It is 0 while reset is low.
- Register write:
  - On the rising edge of clk, when wb_en = 1, regs[wb_addr] <= wb_data.
  - Write latency: 1 edge.
- Register 0:
  - Hardwired to 0.
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0.
- Read ports:
  - Asynchronous (combinational) in rs_addr/rt_addr and register contents.
  - Both ports are independent; the same address on both ports returns the same value.
- Reset:
  - On an edge with reset = 0, registers 1..31 are cleared to 0.
  - Reset has priority over a simultaneous write; the write is lost.
  - Reset asserted mid-stream aborts the retiring write in that cycle.
  - The first write after release occurs on the first edge with reset = 1.
- Output values during and after reset:
  - While reset = 0, rs_data/rt_data reflect stored contents (0 after the first reset edge).
  - wb_addr and wb_data still follow their inputs; wb_en = 0.
- Simultaneous write and read of the same index in one cycle: behaviour set by WB_BYPASS_EN below.
- Out-of-range conditions: none. All 2-bit selects are fully decoded.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Each read port returns wb_data combinationally when wb_en = 1 and the read address equals wb_addr.
  - This gives same-cycle write-before-read, so ID needs no WB->ID forwarding path.
- Undefined:
  - Read ports return stored contents only; the new value is visible the cycle after the write edge.
  - The hazard unit must then cover the WB/ID same-index case, by forwarding or a 1-cycle stall.

Decomposition:
- Shared package: RegDst and MemToReg encodings plus RA_IDX/XP_IDX default constants. The package is shared with the control unit and the hazard/forwarding unit.
- Sub-module reg_file:
  - Contents: 32x32 storage, 2 asynchronous read ports, 1 write port, reset clear, r0 hardwiring, optional bypass.
- wb_regfile:
  - Contents: the RegDst/MemToReg muxes, wb_en generation, and a reg_file instance.

Test Plan:
- Reset hold, then RegWr_in = 1, RegDst = 01, Rd_in = 5, MemToReg = 00, ALU_in = 32'h1234_5678 for one edge, then rs_addr = 5 -> rs_data = 32'h1234_5678 after the edge. rt_addr = 0 -> rt_data = 0.
- Load: RegDst = 00, Rt_in = 9, MemToReg = 01, mem_data_in = 32'hDEAD_BEEF, RegWr = 1 -> wb_addr = 9, wb_en = 1, reg9 = DEAD_BEEF. Then the same with RegWr = 0 and mem_data_in = 32'h1 -> reg9 unchanged.
- jal: RegDst = 10, MemToReg = 10, PC_plus_4_in = 32'h0000_0048 -> reg31 = 0x48. Exception: RegDst = 11, MemToReg = 11, PC_plus_4_in = 32'h0000_0100 -> reg26 = 0x100.
- r0 write: RegDst = 01, Rd_in = 0, ALU_in = 32'hFFFF_FFFF, RegWr = 1 -> wb_en = 0, rs_addr = 0 gives 0.
- Same-cycle read/write: reg7 = 0x11, then write 0x22 to reg7 with rs_addr = rt_addr = 7 during that cycle.
  - With WB_BYPASS_EN: rs_data = rt_data = 0x22 before the edge.
  - Without it: 0x11 before the edge, 0x22 after.
- Reset mid-operation: reg3 = 0xAB, then write 0xCD to reg3 on the same edge that reset = 0 -> reg3 = 0 and wb_en = 0. On the first edge after reset = 1, the write of 0xCD lands.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Encodings and default indices shared by the write-back stage, the control unit
// and the hazard/forwarding unit.
package wb_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int RA_IDX_DEF = 31;
  localparam int XP_IDX_DEF = 26;

  typedef enum logic [1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10,
    REGDST_XP = 2'b11
  } regdst_e;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_MEM = 2'b01,
    M2R_PC4 = 2'b10,
    M2R_EXC = 2'b11
  } memtoreg_e;

endpackage

// File: rtl/wb_regfile_reg_file.sv
// Architectural register file: 2 async read ports, 1 write port, r0 hardwired to 0.
// Define WB_BYPASS_EN to return the write-back value on a same-cycle address match.
module reg_file
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] w_rs_store;
  logic [DATA_W-1:0] w_rt_store;
  logic              w_rs_hit;
  logic              w_rt_hit;

  // Reset wins over a coincident write; entry 0 is never written outside reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_rs_store = (rs_addr == '0) ? '0 : r_regs[rs_addr];
    w_rt_store = (rt_addr == '0) ? '0 : r_regs[rt_addr];
`ifdef WB_BYPASS_EN
    w_rs_hit = wr_en && (rs_addr == wr_addr) && (rs_addr != '0);
    w_rt_hit = wr_en && (rt_addr == wr_addr) && (rt_addr != '0);
`else
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
`endif
  end

  assign rs_data = w_rs_hit ? wr_data : w_rs_store;
  assign rt_data = w_rt_hit ? wr_data : w_rt_store;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: destination/data select, effective write enable, register file.
// Same-cycle WB->ID bypass inside the register file is enabled by WB_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RA_IDX = RA_IDX_DEF,
  parameter int XP_IDX = XP_IDX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        RegDst_in,
  input  logic              RegWr_in,
  input  logic [1:0]        MemToReg_in,
  input  logic [DATA_W-1:0] PC_plus_4_in,
  input  logic [DATA_W-1:0] ALU_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [ADDR_W-1:0] Rt_in,
  input  logic [ADDR_W-1:0] Rd_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam logic [ADDR_W-1:0] RA_ADDR = ADDR_W'(RA_IDX);
  localparam logic [ADDR_W-1:0] XP_ADDR = ADDR_W'(XP_IDX);

  logic [ADDR_W-1:0] w_wb_addr;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_en;

  always_comb begin
    w_wb_addr = Rt_in;
    case (regdst_e'(RegDst_in))
      REGDST_RT: w_wb_addr = Rt_in;
      REGDST_RD: w_wb_addr = Rd_in;
      REGDST_RA: w_wb_addr = RA_ADDR;
      REGDST_XP: w_wb_addr = XP_ADDR;
    endcase
  end

  // Exception entry stores the return address, same as a link.
  always_comb begin
    w_wb_data = ALU_in;
    case (memtoreg_e'(MemToReg_in))
      M2R_ALU: w_wb_data = ALU_in;
      M2R_MEM: w_wb_data = mem_data_in;
      M2R_PC4: w_wb_data = PC_plus_4_in;
      M2R_EXC: w_wb_data = PC_plus_4_in;
    endcase
  end

  assign w_wb_en = RegWr_in && (w_wb_addr != '0) && reset;

  assign wb_en   = w_wb_en;
  assign wb_addr = w_wb_addr;
  assign wb_data = w_wb_data;

  reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wb_en),
    .wr_addr (w_wb_addr),
    .wr_data (w_wb_data),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations are queued as stimulus is applied
// and drained against the outputs a few ns later, away from the clock edge.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  RegDst_in;
  logic        RegWr_in;
  logic [1:0]  MemToReg_in;
  logic [31:0] PC_plus_4_in;
  logic [31:0] ALU_in;
  logic [31:0] mem_data_in;
  logic [4:0]  Rt_in;
  logic [4:0]  Rd_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .RegDst_in    (RegDst_in),
    .RegWr_in     (RegWr_in),
    .MemToReg_in  (MemToReg_in),
    .PC_plus_4_in (PC_plus_4_in),
    .ALU_in       (ALU_in),
    .mem_data_in  (mem_data_in),
    .Rt_in        (Rt_in),
    .Rd_in        (Rd_in),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data)
  );

  localparam int SEL_RS   = 0;
  localparam int SEL_RT   = 1;
  localparam int SEL_EN   = 2;
  localparam int SEL_ADDR = 3;
  localparam int SEL_DATA = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] m_regs [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] m_addr();
    case (RegDst_in)
      2'b00:   return Rt_in;
      2'b01:   return Rd_in;
      2'b10:   return 5'd31;
      default: return 5'd26;
    endcase
  endfunction

  function automatic logic [31:0] m_data();
    case (MemToReg_in)
      2'b00:   return ALU_in;
      2'b01:   return mem_data_in;
      default: return PC_plus_4_in;
    endcase
  endfunction

  function automatic logic m_en();
    return RegWr_in && (m_addr() != 5'd0) && reset;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (m_en() && (a == m_addr())) return m_data();
`endif
    return m_regs[a];
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Queue model expectations for the current inputs, let them settle, then drain.
  task automatic check_now(input string tag);
    sb_t         e;
    logic [31:0] obs;
    expect_val($sformatf("%s/wb_en", tag),   SEL_EN,   {31'd0, m_en()});
    expect_val($sformatf("%s/wb_addr", tag), SEL_ADDR, {27'd0, m_addr()});
    expect_val($sformatf("%s/wb_data", tag), SEL_DATA, m_data());
    expect_val($sformatf("%s/rs_data", tag), SEL_RS,   m_read(rs_addr));
    expect_val($sformatf("%s/rt_data", tag), SEL_RT,   m_read(rt_addr));
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_RS:   obs = rs_data;
        SEL_RT:   obs = rt_data;
        SEL_EN:   obs = {31'd0, wb_en};
        SEL_ADDR: obs = {27'd0, wb_addr};
        default:  obs = wb_data;
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    en = m_en();
    a  = m_addr();
    d  = m_data();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (en) begin
      m_regs[a] = d;
    end
    #1;
  endtask

  task automatic drive(input logic wr, input logic [1:0] dst, input logic [1:0] m2r,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4);
    RegWr_in     = wr;
    RegDst_in    = dst;
    MemToReg_in  = m2r;
    Rt_in        = rt;
    Rd_in        = rd;
    ALU_in       = alu;
    mem_data_in  = mem;
    PC_plus_4_in = pc4;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    reset   = 1'b0;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    tick();
    tick();

    // Reset hold: write attempt is suppressed, addr/data still follow inputs
    drive(1'b1, 2'b01, 2'b00, 5'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
    rs_addr = 5'd5;
    rt_addr = 5'd31;
    expect_val("rst_hold/en0", SEL_EN, 32'h0);
    expect_val("rst_hold/addr5", SEL_ADDR, 32'd5);
    expect_val("rst_hold/rs0", SEL_RS, 32'h0);
    check_now("rst_hold");
    tick();
    check_now("rst_hold2");

    reset = 1'b1;
    expect_val("alu_wr/en1", SEL_EN, 32'h1);
    check_now("alu_wr_pre");
    tick();
    RegWr_in = 1'b0;
    rs_addr  = 5'd5;
    rt_addr  = 5'd0;
    expect_val("alu_wr/rs5", SEL_RS, 32'h1234_5678);
    expect_val("alu_wr/rt0", SEL_RT, 32'h0);
    check_now("alu_wr_post");

    drive(1'b1, 2'b00, 2'b01, 5'd9, 5'd4, 32'h0, 32'hDEAD_BEEF, 32'h0);
    expect_val("load/addr9", SEL_ADDR, 32'd9);
    expect_val("load/en1", SEL_EN, 32'h1);
    check_now("load_pre");
    tick();
    drive(1'b0, 2'b00, 2'b01, 5'd9, 5'd4, 32'h0, 32'h1, 32'h0);
    rs_addr = 5'd9;
    expect_val("load/reg9", SEL_RS, 32'hDEAD_BEEF);
    expect_val("nowr/en0", SEL_EN, 32'h0);
    check_now("nowr_pre");
    tick();
    expect_val("nowr/reg9", SEL_RS, 32'hDEAD_BEEF);
    check_now("nowr_post");

    drive(1'b1, 2'b10, 2'b10, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0000_0048);
    expect_val("jal/addr31", SEL_ADDR, 32'd31);
    check_now("jal_pre");
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0000_0100);
    rs_addr = 5'd31;
    expect_val("exc/addr26", SEL_ADDR, 32'd26);
    expect_val("exc/data", SEL_DATA, 32'h0000_0100);
    check_now("exc_pre");
    tick();
    RegWr_in = 1'b0;
    rt_addr  = 5'd26;
    expect_val("jal/reg31", SEL_RS, 32'h0000_0048);
    expect_val("exc/reg26", SEL_RT, 32'h0000_0100);
    check_now("exc_post");

    drive(1'b1, 2'b01, 2'b00, 5'd3, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    rs_addr = 5'd0;
    expect_val("r0/en0", SEL_EN, 32'h0);
    check_now("r0_pre");
    tick();
    expect_val("r0/rs0", SEL_RS, 32'h0);
    check_now("r0_post");

    drive(1'b1, 2'b01, 2'b00, 5'd0, 5'd7, 32'h11, 32'h0, 32'h0);
    tick();
    drive(1'b1, 2'b01, 2'b00, 5'd0, 5'd7, 32'h22, 32'h0, 32'h0);
    rs_addr = 5'd7;
    rt_addr = 5'd7;
`ifdef WB_BYPASS_EN
    expect_val("byp/rs", SEL_RS, 32'h22);
    expect_val("byp/rt", SEL_RT, 32'h22);
`else
    expect_val("byp/rs", SEL_RS, 32'h11);
    expect_val("byp/rt", SEL_RT, 32'h11);
`endif
    check_now("byp_pre");
    tick();
    RegWr_in = 1'b0;
    expect_val("byp/rs_post", SEL_RS, 32'h22);
    expect_val("byp/rt_post", SEL_RT, 32'h22);
    check_now("byp_post");

    // Reset mid-stream aborts the retiring write; it lands once reset releases
    drive(1'b1, 2'b01, 2'b00, 5'd0, 5'd3, 32'hAB, 32'h0, 32'h0);
    rs_addr = 5'd3;
    rt_addr = 5'd5;
    tick();
    drive(1'b1, 2'b01, 2'b00, 5'd0, 5'd3, 32'hCD, 32'h0, 32'h0);
    reset = 1'b0;
    expect_val("midrst/en0", SEL_EN, 32'h0);
    expect_val("midrst/reg3_old", SEL_RS, 32'hAB);
    check_now("midrst_pre");
    tick();
    expect_val("midrst/reg3_clr", SEL_RS, 32'h0);
    expect_val("midrst/reg5_clr", SEL_RT, 32'h0);
    check_now("midrst_post");
    reset = 1'b1;
    check_now("midrst_rel");
    tick();
    RegWr_in = 1'b0;
    expect_val("midrst/reg3_cd", SEL_RS, 32'hCD);
    check_now("midrst_land");

    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 5'($urandom),
            5'($urandom), $urandom, $urandom, $urandom);
      rs_addr = (i % 4 == 0) ? m_addr() : 5'($urandom);
      rt_addr = 5'($urandom);
      check_now($sformatf("rnd%0d", i));
      tick();
    end

    RegWr_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(i + 16);
      check_now($sformatf("sweep%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
